// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: the machine word, the two-bit byte
// mask, and the state encoding of the instruction/data memory-port arbiter.
package lc3b_types;

  // 16-bit machine word used for addresses and data.
  typedef logic [15:0] lc3b_word;

  // Byte enables for a 16-bit word: bit 1 is the high byte.
  typedef logic [1:0] lc3b_mem_wmask;

  // Arbiter state: free, or owned by fetch (I) or data (D) until the
  // memory acknowledges the access.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } lc3b_arb_state;

endpackage : lc3b_types

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a single memory port between instruction
// fetch (I) and the memory stage (D). D wins ties, except that I is
// guaranteed a grant after STARVE_LIMIT consecutive D grants taken while I
// was waiting. Commands are registered at grant time and held until the
// memory responds. The response and read data are routed back
// combinationally to the owner.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_word      i_rdata,
  output logic          i_resp,

  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_byte_enable,
  output lc3b_word      d_rdata,
  output logic          d_resp,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  // The counter only needs to reach STARVE_LIMIT, where it saturates.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_VAL = CW'(STARVE_LIMIT);

  lc3b_arb_state state_reg;
  logic [CW-1:0] starve_cnt_reg;

  logic d_req;
  logic limit_hit;
  logic grant_i;
  logic grant_d;

  // Grant decision, taken only while the port is free.
  always_comb begin
    d_req     = d_read | d_write;
    limit_hit = (starve_cnt_reg == LIMIT_VAL);
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state_reg == IDLE) begin
      grant_i = i_read & (~d_req | limit_hit);
      grant_d = d_req & ~grant_i;
    end
  end

  // Response routing: only the current owner sees the memory acknowledge;
  // read data is shared and passed through unregistered.
  always_comb begin
    i_resp  = (state_reg == BUSY_I) & pmem_resp;
    d_resp  = (state_reg == BUSY_D) & pmem_resp;
    i_rdata = pmem_rdata;
    d_rdata = pmem_rdata;
  end

  // Ownership FSM and registered memory command. Address, data and enables
  // stay at their last values once a transaction finishes; only the
  // read/write strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_i) begin
            state_reg        <= BUSY_I;
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
            pmem_address     <= i_address;
            pmem_wdata       <= '0;
            pmem_byte_enable <= 2'b11;
          end else if (grant_d) begin
            // A simultaneous read+write request is issued as a write only.
            state_reg        <= BUSY_D;
            pmem_read        <= d_read & ~d_write;
            pmem_write       <= d_write;
            pmem_address     <= d_address;
            pmem_wdata       <= d_wdata;
            pmem_byte_enable <= d_byte_enable;
          end
        end
        BUSY_I, BUSY_D: begin
          if (pmem_resp) begin
            state_reg  <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive D grants that overtook a waiting
  // fetch; any I grant, or a D grant with no fetch waiting, restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (grant_i) begin
      starve_cnt_reg <= '0;
    end else if (grant_d) begin
      if (!i_read) begin
        starve_cnt_reg <= '0;
      end else if (!limit_hit) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

endmodule : mem_port_arbiter
